// File: rtl/noc_pkg.sv
// Shared NoC definitions: default link widths and the link-transmitter FSM encoding.
package noc_pkg;

    localparam int PACKET_WIDTH = 55;
    localparam int STALL_WIDTH  = 8;
    localparam int COUNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } link_state_e;

endpackage

// File: rtl/noc_stage_buf.sv
// Two-entry circular staging buffer between the crossbar and the link FSM.
module noc_stage_buf
    import noc_pkg::*;
#(
    parameter int W = PACKET_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_data_o,
    output logic [1:0]   count_o,
    output logic         full_o
);

    logic [W-1:0] mem_q [2];
    logic         head_q;
    logic         tail_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_i) tail_q <= ~tail_q;
            if (pop_i)  head_q <= ~head_q;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: the count alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[tail_q] <= push_data_i;
    end

    assign head_data_o = mem_q[head_q];
    assign count_o     = count_q;
    assign full_o      = (count_q == 2'd2);

endmodule

// File: rtl/noc_link_tx.sv
// NoC output-port link transmitter: local req/gnt intake, staging, downstream
// req/gnt FSM, sent-packet counter and stall detection.
module noc_link_tx
    import noc_pkg::*;
#(
    parameter int packetwidth = PACKET_WIDTH,
    parameter int stallWidth  = STALL_WIDTH,
    parameter int countWidth  = COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reqIn,
    output logic                   gntIn,
    input  logic [packetwidth-1:0] PacketIn,
    output logic                   stageFull,
    output logic                   reqDnStr,
    input  logic                   gntDnStr,
    output logic [packetwidth-1:0] PacketOut,
    output logic                   busy,
    output logic                   stall,
    output logic [countWidth-1:0]  sentCount
);

    localparam logic [stallWidth-1:0] STALL_MAX = {stallWidth{1'b1}};

    link_state_e            state_q;
    logic                   gnt_in_q;
    logic                   enable_in_q;
    logic                   req_q;
    logic [packetwidth-1:0] pkt_q;
    logic [countWidth-1:0]  sent_q;
    logic [stallWidth-1:0]  stall_cnt_q;

    logic [packetwidth-1:0] head_data;
    logic [1:0]             stage_count;
    logic                   stage_full;
    logic                   accept;
    logic                   pop;

    // Grant decision uses the pre-edge count, so a full buffer refuses even when popping.
    assign accept = reqIn && !stage_full && enable_in_q;
    assign pop    = (state_q == REQ) && gntDnStr;

    noc_stage_buf #(
        .W (packetwidth)
    ) u_stage_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (accept),
        .push_data_i (PacketIn),
        .pop_i       (pop),
        .head_data_o (head_data),
        .count_o     (stage_count),
        .full_o      (stage_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_in_q    <= 1'b0;
            enable_in_q <= 1'b1;
        end else begin
            gnt_in_q <= accept;
            if (!reqIn)      enable_in_q <= 1'b1;
            else if (accept) enable_in_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            pkt_q       <= '0;
            sent_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stage_count != 2'd0) begin
                        pkt_q       <= head_data;
                        req_q       <= 1'b1;
                        stall_cnt_q <= '0;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (gntDnStr) begin
                        req_q   <= 1'b0;
                        sent_q  <= sent_q + countWidth'(1);
                        state_q <= HOLD;
                    end else if (stall_cnt_q != STALL_MAX) begin
                        stall_cnt_q <= stall_cnt_q + stallWidth'(1);
                    end
                end
                HOLD: begin
                    // PacketOut stays put this cycle while the receiver writes it.
                    if (stage_count != 2'd0) begin
                        pkt_q       <= head_data;
                        req_q       <= 1'b1;
                        stall_cnt_q <= '0;
                        state_q     <= REQ;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gntIn     = gnt_in_q;
    assign stageFull = stage_full;
    assign reqDnStr  = req_q;
    assign PacketOut = pkt_q;
    assign sentCount = sent_q;
    assign stall     = (state_q == REQ) && (stall_cnt_q == STALL_MAX);
    assign busy      = (state_q != IDLE) || (stage_count != 2'd0);

endmodule

// File: tb/tb_noc_link_tx.sv
// Directed bench for noc_link_tx with a one-cycle-grant downstream receiver model.
module tb_noc_link_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqIn;
    logic        gntIn;
    logic [54:0] PacketIn;
    logic        stageFull;
    logic        reqDnStr;
    logic        gntDnStr;
    logic [54:0] PacketOut;
    logic        busy;
    logic        stall;
    logic [15:0] sentCount;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit rx_auto  = 1'b0;
    bit rx_ready = 1'b0;

    logic [54:0] delivered [$];
    int          rises     [$];

    noc_link_tx dut (
        .clk       (clk),
        .reset     (reset),
        .reqIn     (reqIn),
        .gntIn     (gntIn),
        .PacketIn  (PacketIn),
        .stageFull (stageFull),
        .reqDnStr  (reqDnStr),
        .gntDnStr  (gntDnStr),
        .PacketOut (PacketOut),
        .busy      (busy),
        .stall     (stall),
        .sentCount (sentCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: the receiver model registers req and answers with a one-cycle grant.
    task automatic tick();
        logic        rp;
        logic        gp;
        logic [54:0] po;
        rp = reqDnStr;
        gp = gntDnStr;
        po = PacketOut;
        @(posedge clk);
        #1;
        cyc++;
        if (rp && gp) delivered.push_back(po);
        if (!rp && reqDnStr) rises.push_back(cyc);
        if (rx_auto) gntDnStr = rx_ready && rp && !gp;
    endtask

    task automatic push(input logic [54:0] d, output bit ok);
        PacketIn = d;
        reqIn    = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (gntIn) begin
                ok = 1'b1;
                break;
            end
        end
        reqIn = 1'b0;
        tick();
    endtask

    initial begin
        bit ok;
        int base;
        int rise_c;

        reset    = 1'b0;
        reqIn    = 1'b0;
        PacketIn = '0;
        gntDnStr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gntIn",     64'(gntIn),     64'd0);
        check("rst_reqDnStr",  64'(reqDnStr),  64'd0);
        check("rst_stall",     64'(stall),     64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_stageFull", 64'(stageFull), 64'd0);
        check("rst_PacketOut", 64'(PacketOut), 64'd0);
        check("rst_sentCount", 64'(sentCount), 64'd0);
        reset = 1'b1;
        repeat (10) tick();
        check("idle10_busy",      64'(busy),      64'd0);
        check("idle10_sentCount", 64'(sentCount), 64'd0);

        // Single packet against an always-ready receiver
        rx_auto  = 1'b1;
        rx_ready = 1'b1;
        delivered.delete();
        push(55'h0A5, ok);
        check("one_accept",      64'(ok),        64'd1);
        check("one_gnt_pulse",   64'(gntIn),     64'd0);
        check("one_req_rise",    64'(reqDnStr),  64'd1);
        check("one_pkt_out",     64'(PacketOut), 64'h0A5);
        tick();
        check("one_req_held",    64'(reqDnStr),  64'd1);
        check("one_sent_before", 64'(sentCount), 64'd0);
        tick();
        check("one_req_drop",    64'(reqDnStr),  64'd0);
        check("one_sent",        64'(sentCount), 64'd1);
        check("one_pkt_hold",    64'(PacketOut), 64'h0A5);
        check("one_delivered_n", 64'(delivered.size()), 64'd1);
        check("one_delivered",   64'(delivered[0]),     64'h0A5);
        tick();
        check("one_idle_busy",   64'(busy),      64'd0);

        // Three back-to-back packets
        delivered.delete();
        rises.delete();
        push(55'h111, ok);
        check("b2b_accept0", 64'(ok), 64'd1);
        push(55'h222, ok);
        check("b2b_accept1", 64'(ok), 64'd1);
        push(55'h333, ok);
        check("b2b_accept2", 64'(ok), 64'd1);
        repeat (10) tick();
        check("b2b_rises_n",  64'(rises.size()),          64'd3);
        check("b2b_gap01",    64'(rises[1] - rises[0]),   64'd3);
        check("b2b_gap12",    64'(rises[2] - rises[1]),   64'd3);
        check("b2b_deliv_n",  64'(delivered.size()),      64'd3);
        check("b2b_deliv0",   64'(delivered[0]),          64'h111);
        check("b2b_deliv1",   64'(delivered[1]),          64'h222);
        check("b2b_deliv2",   64'(delivered[2]),          64'h333);
        check("b2b_sent",     64'(sentCount),             64'd4);

        // Stray downstream grant while IDLE
        rx_auto  = 1'b0;
        gntDnStr = 1'b1;
        tick();
        gntDnStr = 1'b0;
        tick();
        check("idle_gnt_sent", 64'(sentCount), 64'd4);
        check("idle_gnt_busy", 64'(busy),      64'd0);
        check("idle_gnt_req",  64'(reqDnStr),  64'd0);

        // Grant held into HOLD with a second packet staged
        push(55'h0AA, ok);
        push(55'h0BB, ok);
        check("hold_staged_full", 64'(stageFull), 64'd1);
        gntDnStr = 1'b1;
        tick();
        tick();
        gntDnStr = 1'b0;
        check("hold_gnt_sent", 64'(sentCount), 64'd5);
        check("hold_next_req", 64'(reqDnStr),  64'd1);
        check("hold_next_pkt", 64'(PacketOut), 64'h0BB);
        check("hold_full",     64'(stageFull), 64'd0);
        gntDnStr = 1'b1;
        tick();
        gntDnStr = 1'b0;
        tick();
        check("hold_drain_sent", 64'(sentCount), 64'd6);
        check("hold_drain_busy", 64'(busy),      64'd0);

        // Receiver never grants: buffer fills, third push refused, stall asserts
        rx_auto  = 1'b1;
        rx_ready = 1'b0;
        delivered.delete();
        rises.delete();
        push(55'h7_0000_0000_0001, ok);
        check("stall_acc0", 64'(ok), 64'd1);
        push(55'h0_1234_5678_9ABC, ok);
        check("stall_acc1", 64'(ok), 64'd1);
        push(55'h0CC, ok);
        check("stall_refused",   64'(ok),        64'd0);
        check("stall_stageFull", 64'(stageFull), 64'd1);
        rise_c = rises[0];
        for (int i = 0; i < 400 && (cyc - rise_c) < 254; i++) tick();
        check("stall_at_254",    64'(stall),     64'd0);
        tick();
        check("stall_at_255",    64'(stall),     64'd1);
        repeat (3) tick();
        check("stall_saturated", 64'(stall),     64'd1);
        rx_ready = 1'b1;
        base = int'(sentCount);
        tick();
        tick();
        check("stall_cleared",   64'(stall),     64'd0);
        check("stall_sent1",     64'(int'(sentCount) - base), 64'd1);
        repeat (8) tick();
        check("stall_deliv_n",   64'(delivered.size()), 64'd2);
        check("stall_deliv0",    64'(delivered[0]), 64'h7_0000_0000_0001);
        check("stall_deliv1",    64'(delivered[1]), 64'h0_1234_5678_9ABC);
        check("stall_sent_all",  64'(sentCount),    64'd8);

        // Asynchronous reset mid-request with two packets staged
        rx_auto  = 1'b0;
        gntDnStr = 1'b0;
        push(55'h0DD, ok);
        push(55'h0EE, ok);
        check("mid_req_up",  64'(reqDnStr),  64'd1);
        check("mid_full",    64'(stageFull), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_req",       64'(reqDnStr),  64'd0);
        check("arst_stageFull", 64'(stageFull), 64'd0);
        check("arst_busy",      64'(busy),      64'd0);
        check("arst_sent",      64'(sentCount), 64'd0);
        check("arst_pkt",       64'(PacketOut), 64'd0);
        #2;
        reset = 1'b1;
        repeat (5) tick();
        check("post_rst_req",  64'(reqDnStr), 64'd0);
        check("post_rst_busy", 64'(busy),     64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
